// File: rtl/g729_basic_ops.sv
// ---------------------------------------------------------------------------
// g729_basic_ops : saturating G.729 basic operators and LSP->A(z) FSM states
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package g729_basic_ops;

    localparam logic [31:0] MAX_32 = 32'h7FFF_FFFF;
    localparam logic [31:0] MIN_32 = 32'h8000_0000;
    localparam logic [15:0] MAX_16 = 16'h7FFF;
    localparam logic [15:0] MIN_16 = 16'h8000;

    localparam logic [3:0] IDLE  = 4'd0;
    localparam logic [3:0] INIT  = 4'd1;
    localparam logic [3:0] F1    = 4'd2;
    localparam logic [3:0] FETCH = 4'd3;
    localparam logic [3:0] COPY  = 4'd4;
    localparam logic [3:0] INNER = 4'd5;
    localparam logic [3:0] TAIL  = 4'd6;
    localparam logic [3:0] WRITE = 4'd7;
    localparam logic [3:0] DONE  = 4'd8;

    function automatic logic signed [31:0] sx16(input logic [15:0] a);
        return {{16{a[15]}}, a};
    endfunction

    // A 33-bit intermediate overflows when its two top bits disagree.
    function automatic logic [31:0] sat32(input logic [32:0] x);
        if (x[32] != x[31])
            return x[32] ? MIN_32 : MAX_32;
        return x[31:0];
    endfunction

    function automatic logic [31:0] l_add(input logic [31:0] a, input logic [31:0] b);
        return sat32({a[31], a} + {b[31], b});
    endfunction

    function automatic logic [31:0] l_sub(input logic [31:0] a, input logic [31:0] b);
        return sat32({a[31], a} - {b[31], b});
    endfunction

    function automatic logic [31:0] l_mult(input logic [15:0] a, input logic [15:0] b);
        logic signed [31:0] p;
        p = sx16(a) * sx16(b);
        if (p == 32'sh4000_0000)
            return MAX_32;
        return p <<< 1;
    endfunction

    function automatic logic [15:0] mult(input logic [15:0] a, input logic [15:0] b);
        logic signed [31:0] p;
        p = (sx16(a) * sx16(b)) >>> 15;
        if (p > 32'sd32767)
            return MAX_16;
        if (p < -32'sd32768)
            return MIN_16;
        return p[15:0];
    endfunction

    function automatic logic [31:0] l_shl1(input logic [31:0] x);
        if (x[31] != x[30])
            return x[31] ? MIN_32 : MAX_32;
        return {x[30:0], 1'b0};
    endfunction

    // lo is the 15-bit non-negative half from L_Extract, so mult(lo,n) never clamps.
    function automatic logic [31:0] mpy_32_16(input logic [15:0] hi, input logic [14:0] lo,
                                               input logic [15:0] n);
        logic [15:0] m;
        m = mult({1'b0, lo}, n);
        return l_add(l_mult(hi, n), {{15{m[15]}}, m, 1'b0});
    endfunction

endpackage

`default_nettype wire

// File: rtl/mpy32x16_sat.sv
// ---------------------------------------------------------------------------
// mpy32x16_sat : combinational saturating Mpy_32_16 on L_Extract hi/lo halves
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mpy32x16_sat
    import g729_basic_ops::*;
(
    input  logic [15:0] i_hi,
    input  logic [14:0] i_lo,
    input  logic [15:0] i_n,
    output logic [31:0] o_prod
);

    assign o_prod = mpy_32_16(i_hi, i_lo, i_n);

endmodule

`default_nettype wire

// File: rtl/get_lsp_pol_fsm.sv
// ---------------------------------------------------------------------------
// get_lsp_pol_fsm : sequential G.729 Get_lsp_pol, five LSPs -> f[0..5] (Q24)
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module get_lsp_pol_fsm
    import g729_basic_ops::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        sel,
    output logic [3:0]  lspAddr,
    input  logic [15:0] lspIn,
    output logic [2:0]  fAddr,
    output logic [31:0] fOut,
    output logic        fWrite,
    output logic        busy,
    output logic        done
);

    logic [3:0]  r_state;
    logic [3:0]  w_next;
    logic [31:0] r_f [0:5];
    logic [15:0] r_lsp;
    logic [2:0]  r_i;
    logic [2:0]  r_j;
    logic [2:0]  r_widx;
    logic        r_sel;
    logic [2:0]  w_jm1;
    logic [31:0] w_t0;

    assign w_jm1 = r_j - 3'd1;

    mpy32x16_sat u_mpy (
        .i_hi   (r_f[w_jm1][31:16]),
        .i_lo   (r_f[w_jm1][15:1]),
        .i_n    (r_lsp),
        .o_prod (w_t0)
    );

    always_ff @(posedge clk) begin
        if (reset)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start) w_next = INIT;
            INIT:    w_next = F1;
            F1:      w_next = FETCH;
            FETCH:   w_next = COPY;
            COPY:    w_next = INNER;
            INNER:   if (r_j == 3'd2) w_next = TAIL;
            TAIL:    w_next = (r_i == 3'd5) ? WRITE : FETCH;
            WRITE:   if (r_widx == 3'd5) w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        lspAddr = 4'd0;
        fAddr   = 3'd0;
        fOut    = 32'd0;
        fWrite  = 1'b0;
        busy    = (r_state != IDLE);
        done    = (r_state == DONE);
        case (r_state)
            IDLE:      lspAddr = 4'd0;
            INIT, F1:  lspAddr = {3'b000, r_sel};
            WRITE: begin
                lspAddr = {r_i, 1'b0} - 4'd2 + {3'b000, r_sel};
                fWrite  = 1'b1;
                fAddr   = r_widx;
                fOut    = r_f[r_widx];
            end
            default:   lspAddr = {r_i, 1'b0} - 4'd2 + {3'b000, r_sel};
        endcase
    end

    // Inner pass walks j downward so f[j-1] and f[j-2] still hold the previous
    // pass's values when f[j] is rewritten.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < 6; k++)
                r_f[k] <= 32'd0;
            r_lsp  <= 16'd0;
            r_i    <= 3'd2;
            r_j    <= 3'd2;
            r_widx <= 3'd0;
            r_sel  <= 1'b0;
        end else begin
            case (r_state)
                IDLE:  if (start) r_sel <= sel;
                INIT:  r_f[0] <= 32'h0100_0000;
                F1: begin
                    r_f[1] <= l_sub(32'd0, l_mult(lspIn, 16'h0200));
                    r_i    <= 3'd2;
                end
                COPY: begin
                    r_lsp     <= lspIn;
                    r_f[r_i]  <= r_f[r_i - 3'd2];
                    r_j       <= r_i;
                end
                INNER: begin
                    r_f[r_j] <= l_sub(l_add(r_f[r_j], r_f[r_j - 3'd2]), l_shl1(w_t0));
                    if (r_j != 3'd2)
                        r_j <= r_j - 3'd1;
                end
                TAIL: begin
                    r_f[1] <= l_sub(r_f[1], l_mult(r_lsp, 16'h0200));
                    if (r_i == 3'd5)
                        r_widx <= 3'd0;
                    else
                        r_i <= r_i + 3'd1;
                end
                WRITE: r_widx <= r_widx + 3'd1;
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_get_lsp_pol_fsm.sv
// ---------------------------------------------------------------------------
// tb_get_lsp_pol_fsm : directed + random bench against a Get_lsp_pol model
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_get_lsp_pol_fsm;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        sel;
    logic [3:0]  lspAddr;
    logic [15:0] lspIn;
    logic [2:0]  fAddr;
    logic [31:0] fOut;
    logic        fWrite;
    logic        busy;
    logic        done;

    logic [15:0] mem   [0:9];
    longint      exp_f [0:5];
    logic [31:0] cap_d [0:5];
    logic [2:0]  cap_a [0:5];
    int          n_assert = 0;
    int          n_fail   = 0;

    get_lsp_pol_fsm dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .sel     (sel),
        .lspAddr (lspAddr),
        .lspIn   (lspIn),
        .fAddr   (fAddr),
        .fOut    (fOut),
        .fWrite  (fWrite),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) lspIn <= (lspAddr < 4'd10) ? mem[lspAddr] : 16'hDEAD;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic longint m_sat(input longint x);
        if (x > 64'sd2147483647)  return 64'sd2147483647;
        if (x < -64'sd2147483648) return -64'sd2147483648;
        return x;
    endfunction

    function automatic longint m_mult(input longint a, input longint b);
        longint p;
        p = (a * b) >>> 15;
        if (p > 32767)  return 32767;
        if (p < -32768) return -32768;
        return p;
    endfunction

    // Reference recursion on plain integers, straight from the Get_lsp_pol definition.
    task automatic compute_model(input logic s);
        longint l, hi, lo, t0;
        int     so;
        so = s ? 1 : 0;
        exp_f[0] = 64'sd16777216;
        for (int k = 1; k < 6; k++) exp_f[k] = 0;
        l = longint'($signed(mem[so]));
        exp_f[1] = m_sat(0 - 1024 * l);
        for (int i = 2; i <= 5; i++) begin
            l = longint'($signed(mem[2 * i - 2 + so]));
            exp_f[i] = exp_f[i - 2];
            for (int j = i; j >= 2; j--) begin
                hi = exp_f[j - 1] >>> 16;
                lo = (exp_f[j - 1] >>> 1) - hi * 32768;
                t0 = m_sat(m_sat(2 * hi * l) + 2 * m_mult(lo, l));
                t0 = m_sat(2 * t0);
                exp_f[j] = m_sat(m_sat(exp_f[j] + exp_f[j - 2]) - t0);
            end
            exp_f[1] = m_sat(exp_f[1] - 1024 * l);
        end
    endtask

    task automatic run_op(input string name, input logic s, input bit spam);
        int     wr_cnt, done_cnt, done_k, first_wr, bad, late;
        longint e;
        wr_cnt = 0; done_cnt = 0; done_k = 0; first_wr = 0; bad = 0; late = 0;
        for (int k = 0; k < 6; k++) begin cap_d[k] = 'x; cap_a[k] = 'x; end
        compute_model(s);
        @(negedge clk);
        start = 1'b1;
        sel   = s;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (fWrite) begin
                if (wr_cnt < 6) begin
                    cap_a[wr_cnt] = fAddr;
                    cap_d[wr_cnt] = fOut;
                end
                if (wr_cnt == 0) first_wr = k;
                wr_cnt++;
            end
            if (done) begin done_cnt++; done_k = k; end
            if (busy && (lspAddr[0] != s || lspAddr > 4'd9)) bad++;
            if (k > 31 && (busy || fWrite || done)) late++;
            sel   = 1'($urandom_range(0, 1));
            start = spam && (k == 8 || k == 19 || done);
        end
        start = 1'b0;
        check($sformatf("%s done_count", name), 32'(done_cnt), 32'd1);
        check($sformatf("%s done_cycle", name), 32'(done_k), 32'd31);
        check($sformatf("%s write_count", name), 32'(wr_cnt), 32'd6);
        check($sformatf("%s first_write_cycle", name), 32'(first_wr), 32'd25);
        check($sformatf("%s lsp_addr_outside_set", name), 32'(bad), 32'd0);
        check($sformatf("%s activity_after_done", name), 32'(late), 32'd0);
        for (int k = 0; k < 6; k++) begin
            e = exp_f[k];
            check($sformatf("%s fAddr[%0d]", name, k), 32'(cap_a[k]), 32'(k));
            check($sformatf("%s f[%0d]", name, k), cap_d[k], e[31:0]);
        end
    endtask

    task automatic run_abort();
        int leak;
        leak = 0;
        for (int k = 0; k < 10; k++) mem[k] = 16'($urandom);
        @(negedge clk);
        start = 1'b1;
        sel   = 1'($urandom_range(0, 1));
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (k == 12) begin
                check("abort busy_before_reset", 32'(busy), 32'd1);
                reset = 1'b1;
            end else if (k == 13) begin
                check("abort lspAddr", 32'(lspAddr), 32'd0);
                check("abort fAddr", 32'(fAddr), 32'd0);
                check("abort fOut", fOut, 32'd0);
                check("abort fWrite", 32'(fWrite), 32'd0);
                check("abort busy", 32'(busy), 32'd0);
                check("abort done", 32'(done), 32'd0);
                reset = 1'b0;
            end else if (k > 13 && (fWrite || done || busy)) begin
                leak++;
            end
        end
        check("abort activity_after_reset", 32'(leak), 32'd0);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        sel   = 1'b0;
        for (int k = 0; k < 10; k++) mem[k] = 16'h0000;
        repeat (3) @(negedge clk);
        check("reset lspAddr", 32'(lspAddr), 32'd0);
        check("reset fAddr", 32'(fAddr), 32'd0);
        check("reset fOut", fOut, 32'd0);
        check("reset fWrite", 32'(fWrite), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("idle busy", 32'(busy), 32'd0);

        run_op("zero", 1'b0, 1'b0);
        check("zero f2 const", cap_d[2], 32'h0500_0000);
        check("zero f4 const", cap_d[4], 32'h0A00_0000);

        for (int k = 0; k < 10; k++) mem[k] = 16'h4000;
        run_op("half", 1'b0, 1'b0);
        check("half f1 const", cap_d[1], 32'hFB00_0000);

        for (int k = 0; k < 10; k++) mem[k] = 16'h8000;
        run_op("neg_full", 1'b0, 1'b0);
        check("neg_full f1 const", cap_d[1], 32'h0A00_0000);
        check("neg_full f2 const", cap_d[2], 32'h2D00_0000);
        check("neg_full f3 const", cap_d[3], 32'h7800_0000);

        for (int k = 0; k < 10; k++) mem[k] = (k % 2 == 1) ? 16'($urandom) : 16'h7FFF;
        run_op("odd_set", 1'b1, 1'b0);

        for (int k = 0; k < 10; k++) mem[k] = 16'($urandom);
        run_op("start_spam", 1'($urandom_range(0, 1)), 1'b1);

        run_abort();
        for (int k = 0; k < 10; k++) mem[k] = 16'($urandom);
        run_op("after_abort", 1'($urandom_range(0, 1)), 1'b0);

        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < 10; k++) mem[k] = 16'($urandom_range(0, 32767));
            run_op($sformatf("rand%0d", r), 1'($urandom_range(0, 1)), 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
